floor_req_arbiter: RTL and testbench

Round-robin arbiter and tag tracker that shares one `floorf` float-floor pipeline among `N_REQ` requesters. It accepts at most one request per cycle and drives the operand into the pipeline from a register. Because `floorf` has no valid or tag of its own, the arbiter tracks each in-flight operation with a shift register of valid/ID tags. It returns every result to the requester that issued it, in issue order. It sits between the CORDIC-side consumers and the single `floorf` instance.

---
 rtl/floor_req_arbiter_if.sv | 24 ++
 rtl/floor_req_arbiter.sv | 98 +++++++++
 tb/tb_floor_req_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/floor_req_arbiter_if.sv
// Requester-side bundle for floor_req_arbiter: request handshake
// plus the shared response bus and busy flag.
interface floor_req_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    resp_valid;
    logic [IDW-1:0]      resp_id;
    logic [31:0]         resp_data;
    logic                busy;

    modport master (
        output req_valid, req_data,
        input  req_ready, resp_valid, resp_id, resp_data, busy
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, resp_valid, resp_id, resp_data, busy
    );
endinterface

// File: rtl/floor_req_arbiter.sv
// Round-robin arbiter sharing one floorf pipeline; a valid/id tag
// shift register follows each operand so results return to their issuer.
module floor_req_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 2,
    parameter int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    floor_req_arbiter_if.slave bus,
    output logic [31:0]        floor_in,
    input  logic [31:0]        floor_out
);
    localparam logic [IDW:0]   NR   = (IDW+1)'(N_REQ);
    localparam logic [IDW-1:0] LAST = IDW'(N_REQ - 1);

    logic [IDW-1:0]            rr_q, rr_d;
    logic [N_REQ-1:0]          gnt;
    logic [IDW-1:0]            gnt_idx;
    logic [31:0]               gnt_data;
    logic                      found;
    logic                      acc;
    logic [IDW:0]              sum;
    logic [31:0]               floor_in_q, floor_in_d;
    logic [LATENCY:0]          tv_q, tv_d;
    logic [LATENCY:0][IDW-1:0] tid_q, tid_d;
    logic [N_REQ-1:0]          resp_valid_q, resp_valid_d;
    logic [IDW-1:0]            resp_id_q, resp_id_d;
    logic [31:0]               resp_data_q, resp_data_d;

    // Search rr, rr+1, ... modulo N_REQ; first valid requester wins.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        gnt_data = '0;
        found    = 1'b0;
        sum      = '0;
        if (!rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                sum = {1'b0, rr_q} + (IDW+1)'(k);
                if (sum >= NR) sum = sum - NR;
                if (!found && bus.req_valid[sum[IDW-1:0]]) begin
                    found   = 1'b1;
                    gnt_idx = sum[IDW-1:0];
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (found && gnt_idx == IDW'(i)) begin
                    gnt[i]   = 1'b1;
                    gnt_data = bus.req_data[32*i +: 32];
                end
            end
        end
    end

    always_comb begin
        acc  = |gnt;
        rr_d = rr_q;
        if (acc) rr_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        floor_in_d = acc ? gnt_data : floor_in_q;
        tv_d  = {tv_q[LATENCY-1:0], acc};
        tid_d = {tid_q[LATENCY-1:0], gnt_idx};
        resp_valid_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            resp_valid_d[i] = tv_q[LATENCY] && (tid_q[LATENCY] == IDW'(i));
        end
        resp_id_d   = tid_q[LATENCY];
        // floorf has no valid; only capture when a tag says it is live.
        resp_data_d = tv_q[LATENCY] ? floor_out : resp_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q         <= '0;
            floor_in_q   <= '0;
            tv_q         <= '0;
            tid_q        <= '0;
            resp_valid_q <= '0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
        end else begin
            rr_q         <= rr_d;
            floor_in_q   <= floor_in_d;
            tv_q         <= tv_d;
            tid_q        <= tid_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign bus.req_ready  = gnt;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.busy       = (|tv_q) || (|resp_valid_q);
    assign floor_in       = floor_in_q;
endmodule

// File: tb/tb_floor_req_arbiter.sv
// Directed bench for floor_req_arbiter with a two-stage floorf
// stand-in model (positive operands only).
module tb_floor_req_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] floor_in;
    logic [31:0] floor_out;
    logic [31:0] fs1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    floor_req_arbiter_if #(.N_REQ(4)) bus ();

    floor_req_arbiter #(.N_REQ(4), .LATENCY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .floor_in  (floor_in),
        .floor_out (floor_out)
    );

    function automatic logic [31:0] fl(input logic [31:0] x);
        int          e;
        logic [31:0] m;
        e = int'(x[30:23]) - 127;
        if (e < 0) return 32'h0;
        if (e >= 23) return x;
        m = 32'hFFFF_FFFF << (23 - e);
        return x & m;
    endfunction

    // floorf: input registered at E1, result at E2
    always_ff @(posedge clk) begin
        fs1       <= fl(floor_in);
        floor_out <= fs1;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] rdy,
                         input string nm);
        bus.req_valid = v;
        #1;
        chk(nm, 32'(bus.req_ready), 32'(rdy));
    endtask

    task automatic resp(input logic [3:0] rv, input logic [1:0] id,
                        input logic [31:0] d, input string nm);
        chk({nm, "_rv"}, 32'(bus.resp_valid), 32'(rv));
        if (rv != 4'h0) chk({nm, "_id"}, 32'(bus.resp_id), 32'(id));
        chk({nm, "_data"}, bus.resp_data, d);
    endtask

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  rdy;
        logic [3:0]  rv;
        logic [1:0]  id;
        logic [31:0] dat;
        logic        bsy;
    } vec_t;

    vec_t tv[12];

    initial begin
        tv[0]  = '{4'hF, 4'h1, 4'h0, 2'd0, 32'h0000_0000, 1'b1};
        tv[1]  = '{4'hF, 4'h2, 4'h0, 2'd0, 32'h0000_0000, 1'b1};
        tv[2]  = '{4'hF, 4'h4, 4'h0, 2'd0, 32'h0000_0000, 1'b1};
        tv[3]  = '{4'hF, 4'h8, 4'h1, 2'd0, 32'h3F80_0000, 1'b1};
        tv[4]  = '{4'hF, 4'h1, 4'h2, 2'd1, 32'h4000_0000, 1'b1};
        tv[5]  = '{4'hF, 4'h2, 4'h4, 2'd2, 32'h40A0_0000, 1'b1};
        tv[6]  = '{4'hF, 4'h4, 4'h8, 2'd3, 32'h0000_0000, 1'b1};
        tv[7]  = '{4'hF, 4'h8, 4'h1, 2'd0, 32'h3F80_0000, 1'b1};
        tv[8]  = '{4'h0, 4'h0, 4'h2, 2'd1, 32'h4000_0000, 1'b1};
        tv[9]  = '{4'h0, 4'h0, 4'h4, 2'd2, 32'h40A0_0000, 1'b1};
        tv[10] = '{4'h0, 4'h0, 4'h8, 2'd3, 32'h0000_0000, 1'b1};
        tv[11] = '{4'h0, 4'h0, 4'h0, 2'd0, 32'h0000_0000, 1'b0};

        rst = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_data  = {32'h3E80_0000, 32'h40B0_0000,
                         32'h4030_0000, 32'h3FC0_0000};
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        tick();
        chk("rst_rv", 32'(bus.resp_valid), 32'h0);
        chk("rst_id", 32'(bus.resp_id), 32'h0);
        chk("rst_data", bus.resp_data, 32'h0);
        chk("rst_floor_in", floor_in, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;

        // Round robin, all four requesters held for 8 cycles
        for (int r = 0; r < 12; r++) begin
            drive(tv[r].vld, tv[r].rdy, $sformatf("rr%0d_ready", r));
            tick();
            resp(tv[r].rv, tv[r].id, tv[r].dat, $sformatf("rr%0d", r));
            chk($sformatf("rr%0d_busy", r), 32'(bus.busy), 32'(tv[r].bsy));
        end

        // Single request from requester 0
        drive(4'h1, 4'h1, "single_ready");
        tick();
        chk("single_floor_in", floor_in, 32'h3FC0_0000);
        drive(4'h0, 4'h0, "single_idle");
        tick();
        resp(4'h0, 2'd0, 32'h0, "single_e1");
        tick();
        resp(4'h0, 2'd0, 32'h0, "single_e2");
        tick();
        resp(4'h1, 2'd0, 32'h3F80_0000, "single_e3");
        tick();
        resp(4'h0, 2'd0, 32'h3F80_0000, "single_e4");
        chk("single_busy", 32'(bus.busy), 32'h0);

        // Pointer skip: move rr to 2, then only 1 and 3 valid
        drive(4'h2, 4'h2, "skip_setup");
        tick();
        drive(4'hA, 4'h8, "skip_g0");
        tick();
        drive(4'hA, 4'h2, "skip_g1");
        tick();
        drive(4'hA, 4'h8, "skip_g2");
        tick();
        resp(4'h2, 2'd1, 32'h4000_0000, "skip_r0");
        drive(4'h0, 4'h0, "skip_idle");
        tick();
        resp(4'h8, 2'd3, 32'h0, "skip_r1");
        tick();
        resp(4'h2, 2'd1, 32'h4000_0000, "skip_r2");
        tick();
        resp(4'h8, 2'd3, 32'h0, "skip_r3");
        tick();
        resp(4'h0, 2'd0, 32'h0, "skip_r4");

        // Back-to-back from requester 2 with changing data
        bus.req_data[95:64] = 32'h4030_0000;
        drive(4'h4, 4'h4, "b2b_g0");
        tick();
        bus.req_data[95:64] = 32'h40B0_0000;
        drive(4'h4, 4'h4, "b2b_g1");
        tick();
        drive(4'h0, 4'h0, "b2b_idle");
        tick();
        resp(4'h0, 2'd0, 32'h0, "b2b_e2");
        tick();
        resp(4'h4, 2'd2, 32'h4000_0000, "b2b_r0");
        tick();
        resp(4'h4, 2'd2, 32'h40A0_0000, "b2b_r1");
        tick();
        resp(4'h0, 2'd0, 32'h40A0_0000, "b2b_end");

        // Idle after traffic
        for (int c = 0; c < 10; c++) begin
            tick();
            resp(4'h0, 2'd0, 32'h40A0_0000, $sformatf("idle%0d", c));
            chk($sformatf("idle%0d_busy", c), 32'(bus.busy), 32'h0);
        end

        // Reset with three requests in flight (rr is 3 here)
        drive(4'h7, 4'h1, "mid_g0");
        tick();
        drive(4'h7, 4'h2, "mid_g1");
        tick();
        drive(4'h7, 4'h4, "mid_g2");
        tick();
        rst = 1'b1;
        drive(4'h7, 4'h0, "mid_rst_ready");
        tick();
        rst = 1'b0;
        bus.req_valid = 4'h0;
        chk("mid_floor_in", floor_in, 32'h0);
        chk("mid_busy", 32'(bus.busy), 32'h0);
        resp(4'h0, 2'd0, 32'h0, "mid_after");
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("mid_quiet%0d", c), 32'(bus.resp_valid), 32'h0);
            chk($sformatf("mid_quiet%0d_busy", c), 32'(bus.busy), 32'h0);
        end
        drive(4'hC, 4'h4, "post_rst_grant");
        tick();
        chk("post_rst_floor_in", floor_in, 32'h40B0_0000);
        bus.req_valid = 4'h0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
